// File: rtl/router_sync.sv
// router_sync: header address latch, FIFO write steering, full-flag mux and per-port read timeouts.
// Build with ROUTER_SYNC_TIMEOUT_EN defined to include the soft-reset timeout counters.
module router_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_addr,
  input  logic [1:0] din,
  input  logic       wr_en_req,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2
);

  logic [1:0] addr_q;
  logic [2:0] vld;
  logic [2:0] full;

  assign vld  = ~{empty_2, empty_1, empty_0};
  assign full = {full_2, full_1, full_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  // Address 3 is the idle/invalid destination; soft resets leave it alone.
  always_ff @(posedge clk) begin
    if (!rst)
      addr_q <= 2'b11;
    else if (detect_addr)
      addr_q <= din;
  end

  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    if (addr_q != 2'b11) begin
      fifo_full = full[addr_q];
      if (wr_en_req)
        write_enb = 3'b001 << addr_q;
    end
  end

`ifdef ROUTER_SYNC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       rd;
  logic [CNT_W-1:0] cnt_p1 [3];
  logic [2:0]       soft_rst_p1;

  assign rd = {read_enb_2, read_enb_1, read_enb_0};

  // Stage p1: count consecutive valid-but-unread cycles, pulse and restart on the last one.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (!rst) begin
        cnt_p1[n]      <= '0;
        soft_rst_p1[n] <= 1'b0;
      end else if (vld[n] && !rd[n]) begin
        if (cnt_p1[n] == CNT_LAST) begin
          cnt_p1[n]      <= '0;
          soft_rst_p1[n] <= 1'b1;
        end else begin
          cnt_p1[n]      <= cnt_p1[n] + CNT_W'(1);
          soft_rst_p1[n] <= 1'b0;
        end
      end else begin
        cnt_p1[n]      <= '0;
        soft_rst_p1[n] <= 1'b0;
      end
    end
  end

  assign soft_rst_0 = soft_rst_p1[0];
  assign soft_rst_1 = soft_rst_p1[1];
  assign soft_rst_2 = soft_rst_p1[2];
`else
  localparam int unused_cfg = TIMEOUT + CNT_W;
  logic [2:0] unused_rd;

  assign unused_rd  = {read_enb_2, read_enb_1, read_enb_0};
  assign soft_rst_0 = 1'b0;
  assign soft_rst_1 = 1'b0;
  assign soft_rst_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Scoreboard bench for router_sync: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_router_sync;

`ifdef ROUTER_SYNC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       detect_addr;
  logic [1:0] din;
  logic       wr_en_req;
  logic [2:0] empty, full, rd;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .detect_addr(detect_addr),
    .din        (din),
    .wr_en_req  (wr_en_req),
    .empty_0    (empty[0]),
    .empty_1    (empty[1]),
    .empty_2    (empty[2]),
    .full_0     (full[0]),
    .full_1     (full[1]),
    .full_2     (full[2]),
    .read_enb_0 (rd[0]),
    .read_enb_1 (rd[1]),
    .read_enb_2 (rd[2]),
    .write_enb  (write_enb),
    .fifo_full  (fifo_full),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .soft_rst_0 (soft_rst_0),
    .soft_rst_1 (soft_rst_1),
    .soft_rst_2 (soft_rst_2)
  );

  // Outputs are always presented, so the monitor checks one queued entry per cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [9:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
             soft_rst_2, soft_rst_1, soft_rst_0};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got we=%b ff=%b vld=%b srst=%b, required we=%b ff=%b vld=%b srst=%b",
                 e.nm, act[9:7], act[6], act[5:3], act[2:0],
                 e.v[9:7], e.v[6], e.v[5:3], e.v[2:0]);
      end
    end
  end

  function automatic logic [2:0] sr(input logic [2:0] pulses);
    return TO_EN ? pulses : 3'b000;
  endfunction

  // Inputs are already driven; queue the expectation for this cycle, then advance one clock.
  task automatic step(input string nm, input logic [2:0] we, input logic ff, input logic [2:0] srst);
    exp_t e;
    e.nm = nm;
    e.v  = {we, ff, ~empty, sr(srst)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; detect_addr = 1'b0; din = 2'b00; wr_en_req = 1'b0;
    empty = 3'b111; full = 3'b000; rd = 3'b000;
    @(posedge clk); #1;

    // Held reset: vld still follows empty, nothing else moves.
    empty = 3'b101; wr_en_req = 1'b1; full = 3'b111;
    repeat (2) step("reset_hold", 3'b000, 1'b0, 3'b000);
    rst = 1'b1; empty = 3'b111;
    repeat (2) step("no_header", 3'b000, 1'b0, 3'b000);

    // Header to port 2; steering takes effect the cycle after decode.
    detect_addr = 1'b1; din = 2'd2; wr_en_req = 1'b0; full = 3'b100;
    step("hdr2_decode", 3'b000, 1'b0, 3'b000);
    detect_addr = 1'b0; wr_en_req = 1'b1;
    step("p2_write_full", 3'b100, 1'b1, 3'b000);
    full = 3'b000;
    step("p2_write_notfull", 3'b100, 1'b0, 3'b000);
    detect_addr = 1'b1; din = 2'd0; full = 3'b011;
    step("hdr0_old_addr", 3'b100, 1'b0, 3'b000);
    detect_addr = 1'b0;
    step("p0_write", 3'b001, 1'b1, 3'b000);
    detect_addr = 1'b1; din = 2'd1; wr_en_req = 1'b0; full = 3'b101;
    step("hdr1_decode", 3'b000, 1'b1, 3'b000);
    detect_addr = 1'b0; wr_en_req = 1'b1;
    step("p1_write", 3'b010, 1'b0, 3'b000);

    // Invalid header suppresses writes and the full flag.
    detect_addr = 1'b1; din = 2'd3; full = 3'b010;
    step("hdr3_decode", 3'b010, 1'b1, 3'b000);
    detect_addr = 1'b0; full = 3'b111;
    step("invalid_write", 3'b000, 1'b0, 3'b000);
    wr_en_req = 1'b0; full = 3'b000;
    step("invalid_idle", 3'b000, 1'b0, 3'b000);

    // Port 1 valid and unread: pulses in the 31st and 61st cycles.
    empty = 3'b101;
    for (int i = 0; i <= 60; i++)
      step("timeout_p1", 3'b000, 1'b0, (i == 30 || i == 60) ? 3'b010 : 3'b000);
    empty = 3'b111;
    step("timeout_p1_drain", 3'b000, 1'b0, 3'b000);

    // Port 0 rescued by a read in the 30th cycle, then times out 30 cycles later.
    empty = 3'b110;
    for (int i = 0; i < 29; i++)
      step("rescue_p0_pre", 3'b000, 1'b0, 3'b000);
    rd = 3'b001;
    step("rescue_p0_read", 3'b000, 1'b0, 3'b000);
    rd = 3'b000;
    for (int i = 0; i <= 30; i++)
      step("rescue_p0_post", 3'b000, 1'b0, (i == 30) ? 3'b001 : 3'b000);
    empty = 3'b111;
    step("rescue_p0_drain", 3'b000, 1'b0, 3'b000);

    // Ports 0 and 2 together: simultaneous pulse, port 1 silent.
    empty = 3'b010;
    for (int i = 0; i <= 30; i++)
      step("simul_02", 3'b000, 1'b0, (i == 30) ? 3'b101 : 3'b000);
    empty = 3'b111;
    step("simul_02_drain", 3'b000, 1'b0, 3'b000);

    // Same again with a reset mid-count: no pulses at all.
    empty = 3'b010;
    for (int i = 0; i <= 30; i++) begin
      rst = (i == 15) ? 1'b0 : 1'b1;
      step("simul_02_rst", 3'b000, 1'b0, 3'b000);
    end
    rst = 1'b1; empty = 3'b111;
    step("simul_02_rst_drain", 3'b000, 1'b0, 3'b000);

    // Reset cleared addr_q back to invalid.
    wr_en_req = 1'b1; full = 3'b111;
    step("post_rst_addr", 3'b000, 1'b0, 3'b000);
    wr_en_req = 1'b0; full = 3'b000;

    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
